bit_block_stream_counter: RTL and testbench

//  Counts blocks (runs of >= MIN_RUN consecutive target bits) across a multi-word frame.
//  Run state carries across word boundaries and data_enb gaps. Frame ends on data_last.

---
 rtl/bit_block_stream_counter.sv | 190 +++++++++++++++++++
 tb/tb_bit_block_stream_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_block_stream_counter.sv
// Counts runs of >= MIN_RUN target bits across a multi-word frame; three-stage pipeline.
// Optional longest-run tracker is built only when MAX_RUN_EN is defined.
module bit_block_stream_counter #(
   parameter int FF_DLY   = 1,
   parameter int LEN_DATA = 32,
   parameter int LEN_CNT  = 6,
   parameter int LEN_RUN  = 8,
   parameter int MIN_RUN  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LEN_DATA-1:0] data,
   input  logic                data_enb,
   input  logic                data_last,
   input  logic                pol,
   output logic [LEN_CNT-1:0]  block_cnt,
   output logic [LEN_RUN-1:0]  max_run,
   output logic                ovf,
   output logic                valid
);

   localparam int WCNT_W = $clog2(LEN_DATA + 2);
   localparam int SUM_W  = ((LEN_CNT > WCNT_W) ? LEN_CNT : WCNT_W) + 1;

   localparam logic [LEN_RUN-1:0] RUN_MAX   = '1;
   localparam logic [LEN_CNT-1:0] CNT_MAX   = '1;
   localparam logic [LEN_RUN-1:0] MIN_RUN_V = LEN_RUN'(MIN_RUN);

   // Flops are modelled with zero delay; FF_DLY only takes part in the parameter sanity check.
   if (FF_DLY < 0 || MIN_RUN < 1 || MIN_RUN > (2 ** LEN_RUN) - 1) begin : g_illegal_params
   end

   function automatic logic [LEN_RUN-1:0] run_inc(input logic [LEN_RUN-1:0] r);
      return (r == RUN_MAX) ? r : r + LEN_RUN'(1);
   endfunction

   function automatic logic [LEN_CNT-1:0] cnt_sat(input logic [SUM_W-1:0] s);
      return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[LEN_CNT-1:0];
   endfunction

   logic [LEN_DATA-1:0] data_p0;
   logic                enb_p0;
   logic                last_p0;
   logic                pol_p0;
   logic                in_frame;

   logic [LEN_RUN-1:0]  carry_p1;
   logic [WCNT_W-1:0]   cnt_p1;
   logic                enb_p1;
   logic                last_p1;

   logic [LEN_CNT-1:0]  acc_p2;
   logic                ovf_acc_p2;

   logic [LEN_DATA-1:0] tgt;
   logic [LEN_RUN-1:0]  run_c;
   logic [WCNT_W-1:0]   wcnt_c;
   logic [SUM_W-1:0]    sum;
   logic                over;

   // Stage 0: input register; polarity is captured by the first enabled word of a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p0  <= '0;
         enb_p0   <= 1'b0;
         last_p0  <= 1'b0;
         pol_p0   <= 1'b0;
         in_frame <= 1'b0;
      end else begin
         data_p0 <= data;
         enb_p0  <= data_enb;
         last_p0 <= data_last & data_enb;
         if (data_enb) begin
            if (!in_frame)
               pol_p0 <= pol;
            in_frame <= !data_last;
         end
      end
   end

`ifdef MAX_RUN_EN
   logic [LEN_RUN-1:0] wmax_c;
   logic [LEN_RUN-1:0] max_p1;
   logic [LEN_RUN-1:0] fmax_p2;
   logic [LEN_RUN-1:0] fmax_nxt;
   logic [LEN_RUN-1:0] max_run_r;
`endif

   // Stage 1: walk the word from bit 0 upward, extending the run carried in from earlier words
   always_comb begin
      tgt    = pol_p0 ? ~data_p0 : data_p0;
      run_c  = carry_p1;
      wcnt_c = '0;
`ifdef MAX_RUN_EN
      wmax_c = '0;
`endif
      for (int i = 0; i < LEN_DATA; i++) begin
         if (tgt[i]) begin
            run_c = run_inc(run_c);
`ifdef MAX_RUN_EN
            if (run_c > wmax_c)
               wmax_c = run_c;
`endif
         end else begin
            if (run_c >= MIN_RUN_V)
               wcnt_c = wcnt_c + WCNT_W'(1);
            run_c = '0;
         end
      end
      if (last_p0 && run_c >= MIN_RUN_V)
         wcnt_c = wcnt_c + WCNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_p1 <= '0;
         cnt_p1   <= '0;
         enb_p1   <= 1'b0;
         last_p1  <= 1'b0;
`ifdef MAX_RUN_EN
         max_p1   <= '0;
`endif
      end else begin
         enb_p1  <= enb_p0;
         last_p1 <= last_p0;
         if (enb_p0) begin
            carry_p1 <= last_p0 ? '0 : run_c;
            cnt_p1   <= wcnt_c;
`ifdef MAX_RUN_EN
            max_p1   <= wmax_c;
`endif
         end
      end
   end

   // Stage 2: saturating frame accumulator with sticky overflow
   always_comb begin
      sum  = SUM_W'(acc_p2) + SUM_W'(cnt_p1);
      over = (sum > SUM_W'(CNT_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p2     <= '0;
         ovf_acc_p2 <= 1'b0;
         block_cnt  <= '0;
         ovf        <= 1'b0;
         valid      <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (enb_p1) begin
            if (last_p1) begin
               block_cnt  <= cnt_sat(sum);
               ovf        <= ovf_acc_p2 | over;
               valid      <= 1'b1;
               acc_p2     <= '0;
               ovf_acc_p2 <= 1'b0;
            end else begin
               acc_p2     <= cnt_sat(sum);
               ovf_acc_p2 <= ovf_acc_p2 | over;
            end
         end
      end
   end

`ifdef MAX_RUN_EN
   always_comb begin
      fmax_nxt = (max_p1 > fmax_p2) ? max_p1 : fmax_p2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fmax_p2   <= '0;
         max_run_r <= '0;
      end else if (enb_p1) begin
         if (last_p1) begin
            max_run_r <= fmax_nxt;
            fmax_p2   <= '0;
         end else begin
            fmax_p2 <= fmax_nxt;
         end
      end
   end

   assign max_run = max_run_r;
`else
   assign max_run = '0;
`endif

endmodule

// File: tb/tb_bit_block_stream_counter.sv
// Randomized bench for bit_block_stream_counter: frame-level bit-stream model, two count widths.
module tb_bit_block_stream_counter;

   localparam int RUN_CAP = 255;
   localparam int MINR    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data;
   logic        data_enb, data_last, pol;

   logic [5:0]  cnt6;
   logic [3:0]  cnt4;
   logic [7:0]  max6, max4;
   logic        ovf6, ovf4, valid6, valid4;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bit_block_stream_counter #(.LEN_CNT(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .data(data), .data_enb(data_enb), .data_last(data_last),
      .pol(pol), .block_cnt(cnt6), .max_run(max6), .ovf(ovf6), .valid(valid6));

   bit_block_stream_counter #(.LEN_CNT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data(data), .data_enb(data_enb), .data_last(data_last),
      .pol(pol), .block_cnt(cnt4), .max_run(max4), .ovf(ovf4), .valid(valid4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int exp_max(input int m);
`ifdef MAX_RUN_EN
      return m;
`else
      return 0 * m;
`endif
   endfunction

   typedef struct { int cnt; int mx; longint due; } exp_t;
   exp_t   q[$];
   bit     frame[$];
   bit     fpol;
   bit     in_fr;
   longint cyc = 0;

   // Model: collect the frame's target bits in time order; score it when the last word arrives
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         frame.delete();
         q.delete();
         in_fr = 0;
      end else if (data_enb) begin
         if (!in_fr) fpol = pol;
         in_fr = 1;
         for (int i = 0; i < 32; i++) frame.push_back(data[i] ^ fpol);
         if (data_last) begin
            exp_t e;
            int   run;
            run = 0; e.cnt = 0; e.mx = 0;
            foreach (frame[k]) begin
               if (frame[k]) begin
                  run++;
                  if ((run > RUN_CAP ? RUN_CAP : run) > e.mx) e.mx = (run > RUN_CAP ? RUN_CAP : run);
               end else begin
                  if (run >= MINR) e.cnt++;
                  run = 0;
               end
            end
            if (run >= MINR) e.cnt++;
            e.due = cyc + 2;
            q.push_back(e);
            frame.delete();
            in_fr = 0;
         end
      end
   end

   int h_cnt6 = 0, h_cnt4 = 0, h_max = 0;
   bit h_ovf6 = 0, h_ovf4 = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         h_cnt6 = 0; h_cnt4 = 0; h_max = 0; h_ovf6 = 0; h_ovf4 = 0;
         chk("rst_valid", {31'd0, valid6 | valid4}, 32'd0);
         chk("rst_cnt", {22'd0, cnt6, cnt4}, 32'd0);
         chk("rst_ovf_max", {14'd0, ovf6, ovf4, max6, max4}, 32'd0);
      end else begin
         bit due;
         due = (q.size() > 0) && (q[0].due == cyc);
         chk("valid6", {31'd0, valid6}, {31'd0, due});
         chk("valid4", {31'd0, valid4}, {31'd0, due});
         if (due) begin
            exp_t e;
            e = q.pop_front();
            h_cnt6 = (e.cnt > 63) ? 63 : e.cnt;
            h_ovf6 = (e.cnt > 63);
            h_cnt4 = (e.cnt > 15) ? 15 : e.cnt;
            h_ovf4 = (e.cnt > 15);
            h_max  = exp_max(e.mx);
         end
         chk("cnt6", {26'd0, cnt6}, h_cnt6);
         chk("ovf6", {31'd0, ovf6}, {31'd0, h_ovf6});
         chk("cnt4", {28'd0, cnt4}, h_cnt4);
         chk("ovf4", {31'd0, ovf4}, {31'd0, h_ovf4});
         chk("max6", {24'd0, max6}, h_max);
         chk("max4", {24'd0, max4}, h_max);
      end
   end

   task automatic put(input logic [31:0] d, input logic en, input logic l, input logic p);
      data = d; data_enb = en; data_last = l; pol = p;
      @(posedge clk); #1;
   endtask

   // Literal expectations that pin the model against hand-worked frames
   task automatic wait_valid(input string name, input int c6, input int o6, input int c4,
                             input int o4, input int mx);
      bit found;
      found = 0;
      data_enb = 0; data_last = 0;
      for (int k = 0; k < 6 && !found; k++) begin
         @(negedge clk);
         if (valid6) begin
            found = 1;
            chk({name, "_cnt6"}, {26'd0, cnt6}, c6);
            chk({name, "_ovf6"}, {31'd0, ovf6}, o6);
            chk({name, "_cnt4"}, {28'd0, cnt4}, c4);
            chk({name, "_ovf4"}, {31'd0, ovf4}, o4);
            chk({name, "_max"}, {24'd0, max6}, exp_max(mx));
         end
      end
      if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0; data = '0; data_enb = 0; data_last = 0; pol = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;

      put(32'h0000_0006, 1, 1, 0);  wait_valid("t1", 1, 0, 1, 0, 2);
      put(32'h0000_0001, 1, 1, 0);  wait_valid("t2", 0, 0, 0, 0, 1);
      put(32'h8000_0000, 1, 0, 0);
      repeat (3) put(32'hFFFF_FFFF, 0, 0, 0);
      put(32'h0000_0001, 1, 1, 0);  wait_valid("t3", 1, 0, 1, 0, 2);
      put(32'h0000_0000, 1, 1, 1);  wait_valid("t4a", 1, 0, 1, 0, 32);
      put(32'hAAAA_AAAA, 1, 1, 1);  wait_valid("t4b", 0, 0, 0, 0, 1);
      put(32'h0000_0000, 1, 0, 1);
      put(32'h0000_0000, 1, 1, 0);  wait_valid("polhold", 1, 0, 1, 0, 64);
      put(32'h3333_3333, 1, 0, 0);
      put(32'h3333_3333, 1, 1, 0);  wait_valid("t5a", 16, 0, 15, 1, 2);
      put(32'h0000_0006, 1, 1, 0);  wait_valid("t5b", 1, 0, 1, 0, 2);
      for (int i = 0; i < 8; i++) put(32'h3333_3333, 1, i == 7, 0);
      wait_valid("ovf64", 63, 1, 15, 1, 2);
      for (int i = 0; i < 9; i++) put(32'h0000_0000, 1, i == 8, 1);
      wait_valid("runsat", 1, 0, 1, 0, 255);
      put(32'h0000_0006, 1, 0, 0);
      put(32'h0000_0006, 0, 1, 0);
      put(32'h0000_0006, 1, 1, 0);  wait_valid("lastgap", 2, 0, 2, 0, 2);

      put(32'hC000_0000, 1, 0, 0);
      rst_n = 0;
      data_enb = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      put(32'h0000_0001, 1, 1, 0);  wait_valid("t6", 0, 0, 0, 0, 1);

      for (int f = 0; f < 150; f++) begin
         int nw;
         nw = $urandom_range(1, 8);
         for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            case ($urandom_range(0, 5))
               0: d = $urandom;
               1: d = 32'h3333_3333;
               2: d = 32'h0000_0000;
               3: d = 32'hFFFF_FFFF;
               4: d = $urandom & $urandom;
               default: d = $urandom | $urandom;
            endcase
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 2)) put($urandom, 0, 1'($urandom), 1'($urandom));
            put(d, 1, w == nw - 1, 1'($urandom));
         end
      end
      repeat (5) put(32'h0, 0, 0, 0);
      chk("drain", q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
